pilot_removal: RTL and testbench

Receive-side counterpart of the pilot insertion stage. The block accepts a framed stream of 32-bit complex samples in which pilots are interleaved with data, and strips the pilots. It forwards data samples downstream over a valid/ready handshake and presents each pilot on a separate tap for channel estimation. It sits between the receive front end and the demapper.

---
 rtl/pilot_removal.sv | 169 ++++++++++++++++
 tb/tb_pilot_removal.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pilot_removal.sv
// Strips interleaved pilots from a framed sample stream: data goes out over valid/ready,
// pilots go to a strobed tap. Optional build macro PILOT_CHECK_EN flags pilots != PILOT_VALUE.
module pilot_removal #(
  parameter logic [31:0] PILOT_VALUE = 32'h7FFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] signal_in,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  frame_size,
  input  logic [3:0]  pilot_interval,
  output logic [31:0] signal_out,
  output logic        valid,
  input  logic        ready,
  output logic        last,
  output logic [31:0] pilot_out,
  output logic        pilot_valid,
  output logic        error
);

  typedef enum logic [1:0] {START, PILOT, DATA} state_t;

  state_t      state_reg, state_next;
  logic [4:0]  fs_reg, fs_next;
  logic [3:0]  pi_reg, pi_next;
  logic [4:0]  data_cnt_reg, data_cnt_next;
  logic [3:0]  grp_cnt_reg, grp_cnt_next;
  logic [31:0] out_reg, out_next;
  logic        valid_reg, valid_next;
  logic        last_reg, last_next;
  logic [31:0] pilot_reg, pilot_next;
  logic        pilot_valid_reg, pilot_valid_next;
  logic        error_reg, error_next;

  logic        accept;
  logic        pilot_mismatch;
  logic [4:0]  data_cnt_inc;
  logic [3:0]  grp_cnt_inc;

`ifdef PILOT_CHECK_EN
  assign pilot_mismatch = (signal_in != PILOT_VALUE);
`else
  // Constant-folds to zero; keeps the parameter referenced in this build.
  assign pilot_mismatch = 1'b0 && (^PILOT_VALUE);
`endif

  assign in_ready     = !valid_reg || ready;
  assign accept       = in_valid && in_ready;
  assign data_cnt_inc = data_cnt_reg + 5'd1;
  assign grp_cnt_inc  = grp_cnt_reg + 4'd1;

  always_comb begin
    state_next       = state_reg;
    fs_next          = fs_reg;
    pi_next          = pi_reg;
    data_cnt_next    = data_cnt_reg;
    grp_cnt_next     = grp_cnt_reg;
    out_next         = out_reg;
    valid_next       = valid_reg;
    last_next        = last_reg;
    pilot_next       = pilot_reg;
    pilot_valid_next = 1'b0;
    error_next       = error_reg;

    if (valid_reg && ready) begin
      valid_next = 1'b0;
      last_next  = 1'b0;
    end

    case (state_reg)
      START: begin
        if (accept) begin
          fs_next       = frame_size;
          pi_next       = pilot_interval;
          data_cnt_next = 5'd0;
          grp_cnt_next  = 4'd0;
          if (frame_size == 5'd0) begin
            error_next = 1'b1;
          end else if (pilot_interval == 4'd0) begin
            // Pass-through frame: the opening sample is already data.
            out_next   = signal_in;
            valid_next = 1'b1;
            if (frame_size == 5'd1) begin
              last_next = 1'b1;
            end else begin
              last_next     = 1'b0;
              data_cnt_next = 5'd1;
              state_next    = DATA;
            end
          end else begin
            pilot_next       = signal_in;
            pilot_valid_next = 1'b1;
            if (pilot_mismatch) error_next = 1'b1;
            state_next = DATA;
          end
        end
      end

      PILOT: begin
        if (accept) begin
          pilot_next       = signal_in;
          pilot_valid_next = 1'b1;
          if (pilot_mismatch) error_next = 1'b1;
          grp_cnt_next = 4'd0;
          state_next   = DATA;
        end
      end

      DATA: begin
        if (accept) begin
          out_next   = signal_in;
          valid_next = 1'b1;
          last_next  = 1'b0;
          if (data_cnt_inc == fs_reg) begin
            last_next     = 1'b1;
            data_cnt_next = 5'd0;
            grp_cnt_next  = 4'd0;
            state_next    = START;
          end else begin
            data_cnt_next = data_cnt_inc;
            if (pi_reg != 4'd0) begin
              grp_cnt_next = grp_cnt_inc;
              if (grp_cnt_inc == pi_reg) state_next = PILOT;
            end
          end
        end
      end

      default: state_next = START;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= START;
      fs_reg          <= 5'd0;
      pi_reg          <= 4'd0;
      data_cnt_reg    <= 5'd0;
      grp_cnt_reg     <= 4'd0;
      out_reg         <= 32'd0;
      valid_reg       <= 1'b0;
      last_reg        <= 1'b0;
      pilot_reg       <= 32'd0;
      pilot_valid_reg <= 1'b0;
      error_reg       <= 1'b0;
    end else begin
      state_reg       <= state_next;
      fs_reg          <= fs_next;
      pi_reg          <= pi_next;
      data_cnt_reg    <= data_cnt_next;
      grp_cnt_reg     <= grp_cnt_next;
      out_reg         <= out_next;
      valid_reg       <= valid_next;
      last_reg        <= last_next;
      pilot_reg       <= pilot_next;
      pilot_valid_reg <= pilot_valid_next;
      error_reg       <= error_next;
    end
  end

  assign signal_out  = out_reg;
  assign valid       = valid_reg;
  assign last        = last_reg;
  assign pilot_out   = pilot_reg;
  assign pilot_valid = pilot_valid_reg;
  assign error       = error_reg;

endmodule

// File: tb/tb_pilot_removal.sv
// Directed vector bench for pilot_removal: per-cycle records of inputs and
// hand-computed outputs, plus hand sequences for backpressure, reset and pilot check.
module tb_pilot_removal;

  localparam logic [31:0] PV = 32'h7FFF_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] signal_in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  frame_size = '0;
  logic [3:0]  pilot_interval = '0;
  logic [31:0] signal_out;
  logic        valid;
  logic        ready = 1'b1;
  logic        last;
  logic [31:0] pilot_out;
  logic        pilot_valid;
  logic        error;

  int checks = 0;
  int errors = 0;

  pilot_removal dut (
    .clk(clk), .rst(rst), .signal_in(signal_in), .in_valid(in_valid), .in_ready(in_ready),
    .frame_size(frame_size), .pilot_interval(pilot_interval), .signal_out(signal_out),
    .valid(valid), .ready(ready), .last(last), .pilot_out(pilot_out),
    .pilot_valid(pilot_valid), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] din;
    logic [4:0]  fs;
    logic [3:0]  pi;
    logic        rdy;
    logic        ev;
    logic [31:0] eo;
    logic        el;
    logic        epv;
    logic [31:0] epo;
    logic        ee;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic iv, logic [31:0] din, logic [4:0] fs, logic [3:0] pi,
                              logic rdy, logic ev, logic [31:0] eo, logic el,
                              logic epv, logic [31:0] epo, logic ee);
    vec_t v;
    v.iv = iv; v.din = din; v.fs = fs; v.pi = pi; v.rdy = rdy;
    v.ev = ev; v.eo = eo; v.el = el; v.epv = epv; v.epo = epo; v.ee = ee;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, then compare the registered outputs.
  task automatic step(input vec_t v, input string name);
    in_valid = v.iv; signal_in = v.din; frame_size = v.fs; pilot_interval = v.pi; ready = v.rdy;
    @(posedge clk);
    #1;
    chk({name, ".valid"}, {31'd0, valid}, {31'd0, v.ev});
    chk({name, ".last"}, {31'd0, last}, {31'd0, v.el});
    chk({name, ".pilot_valid"}, {31'd0, pilot_valid}, {31'd0, v.epv});
    chk({name, ".error"}, {31'd0, error}, {31'd0, v.ee});
    if (v.ev) chk({name, ".signal_out"}, signal_out, v.eo);
    if (v.epv) chk({name, ".pilot_out"}, pilot_out, v.epo);
    $display("%s: in=%h iv=%0d rdy=%0d -> valid=%0d out=%h last=%0d pv=%0d pilot=%h err=%0d",
             name, v.din, v.iv, v.rdy, valid, signal_out, last, pilot_valid, pilot_out, error);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Six data, interval 2
    vecs.push_back(mk(1, PV,           6, 2, 1, 0, 0,            0, 1, PV, 0));
    vecs.push_back(mk(1, 32'hA000_0000, 6, 2, 1, 1, 32'hA000_0000, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'hA000_0001, 6, 2, 1, 1, 32'hA000_0001, 0, 0, 0, 0));
    vecs.push_back(mk(1, PV,           6, 2, 1, 0, 0,            0, 1, PV, 0));
    vecs.push_back(mk(1, 32'hA000_0002, 6, 2, 1, 1, 32'hA000_0002, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'hA000_0003, 6, 2, 1, 1, 32'hA000_0003, 0, 0, 0, 0));
    vecs.push_back(mk(1, PV,           6, 2, 1, 0, 0,            0, 1, PV, 0));
    vecs.push_back(mk(1, 32'hA000_0004, 6, 2, 1, 1, 32'hA000_0004, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'hA000_0005, 6, 2, 1, 1, 32'hA000_0005, 1, 0, 0, 0));
    vecs.push_back(mk(0, 32'h0,        6, 2, 1, 0, 0,            0, 0, 0, 0));
    // Five data, interval 2: short final group
    vecs.push_back(mk(1, PV,           5, 2, 1, 0, 0,            0, 1, PV, 0));
    vecs.push_back(mk(1, 32'hB000_0000, 9, 7, 1, 1, 32'hB000_0000, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'hB000_0001, 9, 7, 1, 1, 32'hB000_0001, 0, 0, 0, 0));
    vecs.push_back(mk(1, PV,           9, 7, 1, 0, 0,            0, 1, PV, 0));
    vecs.push_back(mk(1, 32'hB000_0002, 9, 7, 1, 1, 32'hB000_0002, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'hB000_0003, 9, 7, 1, 1, 32'hB000_0003, 0, 0, 0, 0));
    vecs.push_back(mk(1, PV,           9, 7, 1, 0, 0,            0, 1, PV, 0));
    vecs.push_back(mk(1, 32'hB000_0004, 9, 7, 1, 1, 32'hB000_0004, 1, 0, 0, 0));
    vecs.push_back(mk(1, 32'h1234_5678, 1, 2, 1, 0, 0,            0, 1, 32'h1234_5678, 0));
    vecs.push_back(mk(1, 32'hB000_0005, 1, 2, 1, 1, 32'hB000_0005, 1, 0, 0, 0));
    // No pilots, three data per frame
    vecs.push_back(mk(1, 32'hC000_0000, 3, 0, 1, 1, 32'hC000_0000, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'hC000_0001, 3, 0, 1, 1, 32'hC000_0001, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'hC000_0002, 3, 0, 1, 1, 32'hC000_0002, 1, 0, 0, 0));
    vecs.push_back(mk(1, 32'hC000_0003, 3, 0, 1, 1, 32'hC000_0003, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'hC000_0004, 3, 0, 1, 1, 32'hC000_0004, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'hC000_0005, 3, 0, 1, 1, 32'hC000_0005, 1, 0, 0, 0));
    vecs.push_back(mk(0, 32'h0,        3, 0, 1, 0, 0,            0, 0, 0, 0));

    // Reset state
    #2;
    chk("reset.in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset.valid", {31'd0, valid}, 32'd0);
    chk("reset.signal_out", signal_out, 32'd0);
    chk("reset.pilot_out", pilot_out, 32'd0);
    chk("reset.error", {31'd0, error}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: D0 held for four cycles while a pilot waits upstream
    step(mk(1, PV, 2, 1, 1, 0, 0, 0, 1, PV, 0), "bp.pilot0");
    step(mk(1, 32'hD000_0000, 2, 1, 0, 1, 32'hD000_0000, 0, 0, 0, 0), "bp.d0");
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp.hold%0d.in_ready", k), {31'd0, in_ready}, 32'd0);
      step(mk(1, PV, 2, 1, 0, 1, 32'hD000_0000, 0, 0, 0, 0), $sformatf("bp.hold%0d", k));
    end
    ready = 1'b1;
    #1;
    chk("bp.release.in_ready", {31'd0, in_ready}, 32'd1);
    step(mk(1, PV, 2, 1, 1, 0, 0, 0, 1, PV, 0), "bp.pilot1");
    step(mk(1, 32'hD000_0001, 2, 1, 1, 1, 32'hD000_0001, 1, 0, 0, 0), "bp.d1");
    step(mk(0, 0, 2, 1, 1, 0, 0, 0, 0, 0, 0), "bp.idle");

    // Zero frame size: sticky error, sample dropped
    step(mk(1, 32'hE000_0000, 0, 2, 1, 0, 0, 0, 0, 0, 1), "fs0.drop");
    step(mk(1, 32'hE000_0001, 1, 0, 1, 1, 32'hE000_0001, 1, 0, 0, 1), "fs0.after");
    step(mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1), "fs0.idle");

    // Reset in the middle of a frame
    step(mk(1, PV, 4, 2, 1, 0, 0, 0, 1, PV, 1), "rst.pilot");
    step(mk(1, 32'hF000_0000, 4, 2, 0, 1, 32'hF000_0000, 0, 0, 0, 1), "rst.d0");
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst.valid", {31'd0, valid}, 32'd0);
    chk("rst.signal_out", signal_out, 32'd0);
    chk("rst.last", {31'd0, last}, 32'd0);
    chk("rst.pilot_valid", {31'd0, pilot_valid}, 32'd0);
    chk("rst.pilot_out", pilot_out, 32'd0);
    chk("rst.error", {31'd0, error}, 32'd0);
    chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    step(mk(1, 32'h5555_AAAA, 2, 1, 1, 0, 0, 0, 1, 32'h5555_AAAA, 0), "rst.first_is_pilot");
    step(mk(1, 32'hF000_0001, 2, 1, 1, 1, 32'hF000_0001, 0, 0, 0, 0), "rst.d0b");
    step(mk(1, PV, 2, 1, 1, 0, 0, 0, 1, PV, 0), "rst.pilot2");
    step(mk(1, 32'hF000_0002, 2, 1, 1, 1, 32'hF000_0002, 1, 0, 0, 0), "rst.d1b");

`ifdef PILOT_CHECK_EN
    step(mk(1, PV, 1, 1, 1, 0, 0, 0, 1, PV, 0), "chk.good");
    step(mk(1, 32'h0101_0101, 1, 1, 1, 1, 32'h0101_0101, 1, 0, 0, 0), "chk.good_d");
    step(mk(1, 32'h0000_7FFF, 1, 1, 1, 0, 0, 0, 1, 32'h0000_7FFF, 1), "chk.bad");
    step(mk(1, 32'h0202_0202, 1, 1, 1, 1, 32'h0202_0202, 1, 0, 0, 1), "chk.bad_d");
`else
    step(mk(1, 32'h0000_7FFF, 1, 1, 1, 0, 0, 0, 1, 32'h0000_7FFF, 0), "nochk.pilot");
    step(mk(1, 32'h0202_0202, 1, 1, 1, 1, 32'h0202_0202, 1, 0, 0, 0), "nochk.d");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
